// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MUL results onto one register-file write port.
// The ALU path is unbuffered and has priority; LSU and MUL results queue in small FIFOs.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [38:0] alu_wb_inf,
    input  logic [38:0] lsu_wb_inf,
    input  logic [38:0] mul_wb_inf,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  retire_count,
    output logic [63:0] instret
);

    // Input bundle layout: {instruction_valid, register_write, rd[4:0], exe_result[31:0]}
    localparam int VALID_BIT = 38;
    localparam int WRITE_BIT = 37;
    localparam int ENTRY_W   = 37;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Index 0 is the LSU FIFO, index 1 the MUL FIFO; lower index wins arbitration.
    logic [ENTRY_W-1:0] mem_q [2][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [2];
    logic [PTR_W-1:0]   wr_ptr_d [2];
    logic [PTR_W-1:0]   rd_ptr_q [2];
    logic [PTR_W-1:0]   rd_ptr_d [2];
    logic [CNT_W-1:0]   cnt_q [2];
    logic [CNT_W-1:0]   cnt_d [2];
    logic [ENTRY_W-1:0] in_entry_s [2];
    logic [1:0]         push_s;
    logic [1:0]         pop_s;
    logic               consume_s;
    logic               alu_req_s;
    logic               grant_s;
    logic [ENTRY_W-1:0] grant_entry_s;

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [1:0]  retire_q, retire_d;
    logic [63:0] instret_q, instret_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign wb_stall     = (cnt_q[0] == FULL_CNT) || (cnt_q[1] == FULL_CNT);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_count = retire_q;
    assign instret      = instret_q;

    // Consumption, arbitration, FIFO bookkeeping and write-port next state.
    always_comb begin
        consume_s     = !wb_stall;
        in_entry_s[0] = lsu_wb_inf[ENTRY_W-1:0];
        in_entry_s[1] = mul_wb_inf[ENTRY_W-1:0];
        push_s[0]     = consume_s && lsu_wb_inf[VALID_BIT] && lsu_wb_inf[WRITE_BIT];
        push_s[1]     = consume_s && mul_wb_inf[VALID_BIT] && mul_wb_inf[WRITE_BIT];
        alu_req_s     = consume_s && alu_wb_inf[VALID_BIT] && alu_wb_inf[WRITE_BIT];
        pop_s         = 2'b00;
        grant_s       = 1'b0;
        grant_entry_s = '0;

        if (alu_req_s) begin
            grant_s       = 1'b1;
            grant_entry_s = alu_wb_inf[ENTRY_W-1:0];
        end else if (cnt_q[0] != '0) begin
            grant_s       = 1'b1;
            pop_s[0]      = 1'b1;
            grant_entry_s = mem_q[0][rd_ptr_q[0]];
        end else if (cnt_q[1] != '0) begin
            grant_s       = 1'b1;
            pop_s[1]      = 1'b1;
            grant_entry_s = mem_q[1][rd_ptr_q[1]];
        end else begin
            grant_s       = 1'b0;
        end

        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = push_s[i] ? next_ptr(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop_s[i]  ? next_ptr(rd_ptr_q[i]) : rd_ptr_q[i];
            case ({push_s[i], pop_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end

        // rd=0 still moves address/data so the port reflects the granted entry.
        rf_we_d    = grant_s && (grant_entry_s[36:32] != 5'd0);
        rf_waddr_d = grant_s ? grant_entry_s[36:32] : rf_waddr_q;
        rf_wdata_d = grant_s ? grant_entry_s[31:0]  : rf_wdata_q;

        if (consume_s) begin
            retire_d = {1'b0, alu_wb_inf[VALID_BIT]} + {1'b0, lsu_wb_inf[VALID_BIT]}
                     + {1'b0, mul_wb_inf[VALID_BIT]};
        end else begin
            retire_d = 2'd0;
        end
        instret_d = instret_q + {62'd0, retire_q};
    end

    // FIFO control state and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            retire_q   <= 2'd0;
            instret_q  <= 64'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retire_q   <= retire_d;
            instret_q  <= instret_d;
        end
    end

    // FIFO storage; entries are only meaningful while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_entry_s[i];
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_arbiter;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [38:0] alu_i, lsu_i, mul_i;
    logic        wb_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  retire_count;
    logic [63:0] instret;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [36:0] lsu_q[$];
    logic [36:0] mul_q[$];
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_ret;
    logic [63:0] exp_instret;

    writeback_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_inf(alu_i), .lsu_wb_inf(lsu_i), .mul_wb_inf(mul_i),
        .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_count(retire_count), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [38:0] mk(input logic v, input logic w, input logic [4:0] rd,
                                       input logic [31:0] d);
        return {v, w, rd, d};
    endfunction

    function automatic logic [38:0] rnd_in();
        return mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)), $urandom);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        lsu_q.delete();
        mul_q.delete();
        exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0;
        exp_ret = 2'd0; exp_instret = 64'd0;
    endtask

    task automatic compare_all();
        check("rf_we", 64'(rf_we), 64'(exp_we));
        check("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
        check("retire_count", 64'(retire_count), 64'(exp_ret));
        check("instret", instret, exp_instret);
        check("wb_stall", 64'(wb_stall), 64'((lsu_q.size() == D) || (mul_q.size() == D)));
    endtask

    // One clock: drive inputs, advance the model through the edge, compare after it.
    task automatic step(input logic [38:0] a, input logic [38:0] l, input logic [38:0] m);
        bit stall;
        bit granted;
        logic [36:0] g;
        int n;
        alu_i = a; lsu_i = l; mul_i = m;
        stall = (lsu_q.size() == D) || (mul_q.size() == D);
        granted = 1'b0;
        g = '0;
        n = 0;
        if (!stall && a[38] && a[37]) begin
            granted = 1'b1; g = a[36:0];
        end else if (lsu_q.size() > 0) begin
            granted = 1'b1; g = lsu_q.pop_front();
        end else if (mul_q.size() > 0) begin
            granted = 1'b1; g = mul_q.pop_front();
        end
        if (!stall) begin
            if (l[38] && l[37]) begin
                if (lsu_q.size() >= D) begin bad++; total++; $display("FAIL lsu_push_full"); end
                lsu_q.push_back(l[36:0]);
            end
            if (m[38] && m[37]) begin
                if (mul_q.size() >= D) begin bad++; total++; $display("FAIL mul_push_full"); end
                mul_q.push_back(m[36:0]);
            end
            n = int'(a[38]) + int'(l[38]) + int'(m[38]);
        end
        exp_instret = exp_instret + 64'(exp_ret);
        exp_ret = 2'(n);
        exp_we = granted && (g[36:32] != 5'd0);
        if (granted) begin
            exp_waddr = g[36:32];
            exp_wdata = g[31:0];
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(39'd0, 39'd0, 39'd0);
    endtask

    initial begin
        rst = 1'b1;
        alu_i = '0; lsu_i = '0; mul_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_instret", instret, 64'd0);
        check("reset_stall", 64'(wb_stall), 64'd0);
        rst = 1'b0;

        // ALU write rd=5
        step(mk(1, 1, 5'd5, 32'h0000_1234), 39'd0, 39'd0);
        check("s1_we", 64'(rf_we), 64'd1);
        check("s1_waddr", 64'(rf_waddr), 64'd5);
        check("s1_wdata", 64'(rf_wdata), 64'h1234);
        check("s1_retire", 64'(retire_count), 64'd1);
        idle();
        check("s1_instret", instret, 64'd1);

        // Three valid non-writing inputs
        step(mk(1, 0, 5'd1, 32'd1), mk(1, 0, 5'd2, 32'd2), mk(1, 0, 5'd3, 32'd3));
        check("s5_we", 64'(rf_we), 64'd0);
        check("s5_retire", 64'(retire_count), 64'd3);
        idle();
        check("s5_instret", instret, 64'd4);

        // ALU rd=3 with LSU rd=7
        step(mk(1, 1, 5'd3, 32'h33), mk(1, 1, 5'd7, 32'h77), 39'd0);
        check("s2_waddr_t1", 64'(rf_waddr), 64'd3);
        check("s2_retire", 64'(retire_count), 64'd2);
        idle();
        check("s2_we_t2", 64'(rf_we), 64'd1);
        check("s2_waddr_t2", 64'(rf_waddr), 64'd7);
        check("s2_wdata_t2", 64'(rf_wdata), 64'h77);

        // ALU rd=0
        step(mk(1, 1, 5'd0, 32'hFFFF_FFFF), 39'd0, 39'd0);
        check("s4_we", 64'(rf_we), 64'd0);
        check("s4_wdata", 64'(rf_wdata), 64'hFFFF_FFFF);
        check("s4_retire", 64'(retire_count), 64'd1);

        // Fill both FIFOs behind a busy ALU, then drain
        step(mk(1, 1, 5'd1, 32'h1), mk(1, 1, 5'd10, 32'hA0), mk(1, 1, 5'd20, 32'hB0));
        step(mk(1, 1, 5'd2, 32'h2), mk(1, 1, 5'd11, 32'hA1), mk(1, 1, 5'd21, 32'hB1));
        check("s3_stall_full", 64'(wb_stall), 64'd1);
        step(mk(1, 1, 5'd4, 32'h4), mk(1, 1, 5'd12, 32'hA2), mk(1, 1, 5'd22, 32'hB2));
        check("s3_lsu0", 64'(rf_wdata), 64'hA0);
        check("s3_retire_stalled", 64'(retire_count), 64'd0);
        step(mk(1, 1, 5'd4, 32'h4), 39'd0, 39'd0);
        check("s3_lsu1", 64'(rf_wdata), 64'hA1);
        check("s3_stall_mul_full", 64'(wb_stall), 64'd1);
        idle();
        check("s3_mul0", 64'(rf_wdata), 64'hB0);
        check("s3_stall_drop", 64'(wb_stall), 64'd0);
        idle();
        check("s3_mul1", 64'(rf_wdata), 64'hB1);
        check("s3_mul1_addr", 64'(rf_waddr), 64'd21);

        // Reset with two entries buffered
        step(mk(1, 1, 5'd1, 32'h1), mk(1, 1, 5'd9, 32'h90), 39'd0);
        step(mk(1, 1, 5'd2, 32'h2), mk(1, 1, 5'd8, 32'h80), 39'd0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("s6_waddr_zero", 64'(rf_waddr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) idle();
        check("s6_no_write", 64'(rf_we), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(rnd_in(), rnd_in(), rnd_in());
        end
        repeat (6) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, named as the codebase does: clk, rst.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  core clock
- rst  in  1  async active-high reset
- alu_wb_inf  in  exe_wb_inf_t  ALU result: instruction_valid, register_write, rd[4:0], exe_result[31:0]
- lsu_wb_inf  in  exe_wb_inf_t  load/store unit result
- mul_wb_inf  in  exe_wb_inf_t  multiply/divide unit result
- wb_stall  out  1  to core; inputs not consumed this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- retire_count  out  2  instructions retired this cycle (0-3)
- instret  out  64  retired-instruction counter
REQ-003 SHALL define parameter FIFO_DEPTH, default 2, meaning entries per buffered source (LSU, MUL).

Function
REQ-004 SHALL consume the inputs only in cycles where wb_stall=0; while wb_stall=1, inputs SHALL be ignored (upstream holds them and re-presents them).
REQ-005 An input is a write request when instruction_valid=1, register_write=1 and it is consumed.
REQ-006 An ALU write request SHALL have absolute priority and appear on rf_* at the next clock edge (latency 1); the ALU path is never buffered.
REQ-007 LSU and MUL write requests SHALL be pushed into their own FIFO_DEPTH-entry FIFOs; there is no bypass, so minimum latency is 2.
REQ-008 When there is no ALU write request, the write port SHALL take, in priority order, the LSU FIFO head, then the MUL FIFO head; exactly one entry is popped per granted cycle.
REQ-009 Simultaneous push and pop of the same FIFO SHALL leave its count unchanged and preserve FIFO order.
REQ-010 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-011 wb_stall SHALL be a combinational function of registered state: 1 when either FIFO count equals FIFO_DEPTH, else 0.
REQ-012 A push to a full FIFO SHALL never occur; the bench flags it as an error.
REQ-013 rf_we SHALL be 1 for one cycle per granted entry, except when rd=0: then rf_we=0, while rf_waddr/rf_wdata still update.
REQ-014 retire_count SHALL count consumed inputs with instruction_valid=1 (any register_write), registered one cycle after consumption; instret SHALL add retire_count each cycle, wrapping at 2^64.
REQ-015 Entries with instruction_valid=0, or with register_write=0, SHALL never occupy a FIFO or the write port.
REQ-016 Ordering between the ALU and buffered writes to the same rd is the dispatcher's responsibility; this block preserves per-source order only.
REQ-017 There is no flush input; consumed results are committed.

Reset
REQ-018 On rst=1, asynchronously: FIFO counts/pointers=0, rf_we=0, rf_waddr=0, rf_wdata=0, retire_count=0, instret=0, wb_stall=0.
REQ-019 Reset mid-operation SHALL discard all buffered entries without issuing writes.

Verification
REQ-020 Scenarios the bench SHALL cover:
- ALU write rd=5, data=0x0000_1234 in cycle t -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 in cycle t+1; retire_count=1; instret=1.
- ALU rd=3 and LSU rd=7 in the same cycle -> rd=3 written at t+1, rd=7 at t+2; retire_count=2 at t+1.
- LSU and MUL pushed with ALU busy every cycle -> both FIFOs fill to 2, wb_stall=1; ALU input ignored; drain order LSU0, LSU1, MUL0, MUL1; wb_stall drops once no FIFO is full.
- ALU write rd=0, data=0xFFFF_FFFF -> rf_we=0 at t+1; retire_count=1.
- Three valid non-writing inputs (register_write=0) in one cycle -> no rf_we; retire_count=3; instret +3.
- Two entries buffered, rst asserted mid-cycle -> all outputs 0 immediately; no writes after release.
